// File: rtl/panda_pkg.sv
// +-----------------------------------------------------------------------+
// | panda_pkg: shared types and defaults for the panda shift datapath.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package panda_pkg;

  localparam int DefaultWidth = 32;
  localparam int DefaultAmtW  = $clog2(DefaultWidth);

  typedef struct packed {
    logic                   left;
    logic                   arith;
    logic [DefaultWidth-1:0] operand;
    logic [DefaultAmtW-1:0]  amount;
  } shift_req_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/panda_rr_arbiter.sv
// +-----------------------------------------------------------------------+
// | panda_rr_arbiter: valid vector -> one-hot grant and index.            |
// | PANDA_SHIFT_ARB_RR_EN selects round-robin, else fixed priority.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module panda_rr_arbiter #(
  parameter int  NumReq = 2,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
`ifdef PANDA_SHIFT_ARB_RR_EN
  input  logic [IdW-1:0]    ptr_i,
`endif
  output logic [NumReq-1:0] grant_o,
  output logic [IdW-1:0]    idx_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
`ifdef PANDA_SHIFT_ARB_RR_EN
    // Search starts one past the last winner and wraps around.
    for (int k = 1; k <= NumReq; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IdW'(cand);
      end
    end
`else
    for (int i = 0; i < NumReq; i++) begin
      cand = i;
      if (!found && valid_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IdW'(cand);
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/panda_shifter.sv
// +-----------------------------------------------------------------------+
// | panda_shifter: combinational left / logical-right / arith-right shift.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module panda_shifter
  import panda_pkg::*;
#(
  parameter int  Width = DefaultWidth,
  localparam int AmtW  = $clog2(Width)
) (
  input  logic             left_i,
  input  logic             arith_i,
  input  logic [Width-1:0] operand_i,
  input  logic [AmtW-1:0]  amount_i,
  output logic [Width-1:0] result_o
);

  always_comb begin
    result_o = operand_i;
    if (left_i) begin
      result_o = operand_i << amount_i;
    end else if (arith_i) begin
      result_o = $signed(operand_i) >>> amount_i;
    end else begin
      result_o = operand_i >> amount_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/panda_shift_arbiter.sv
// +-----------------------------------------------------------------------+
// | panda_shift_arbiter: shares one shifter among NumReq requesters with  |
// | a registered single-entry response slot. Macro PANDA_SHIFT_ARB_RR_EN. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module panda_shift_arbiter
  import panda_pkg::*;
#(
  parameter int  Width  = DefaultWidth,
  parameter int  NumReq = 2,
  localparam int IdW    = $clog2(NumReq),
  localparam int AmtW   = $clog2(Width)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq-1:0]      req_left_i,
  input  logic [NumReq-1:0]      req_arith_i,
  input  logic [NumReq*Width-1:0] req_operand_i,
  input  logic [NumReq*AmtW-1:0] req_amount_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [Width-1:0]       resp_result_o,
  output logic [IdW-1:0]         resp_id_o
);

  slot_state_e      state_q, state_d;
  logic [Width-1:0] result_q, result_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [NumReq-1:0] grant;
  logic [IdW-1:0]   gnt_idx;
  logic             can_accept;
  logic             handshake;

  logic             sel_left, sel_arith;
  logic [Width-1:0] sel_operand;
  logic [AmtW-1:0]  sel_amount;
  logic [Width-1:0] shift_res;

`ifdef PANDA_SHIFT_ARB_RR_EN
  logic [IdW-1:0]   ptr_q, ptr_d;
`endif

  panda_rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .valid_i (req_valid_i),
`ifdef PANDA_SHIFT_ARB_RR_EN
    .ptr_i   (ptr_q),
`endif
    .grant_o (grant),
    .idx_o   (gnt_idx)
  );

  assign resp_valid_o  = (state_q == SLOT_FULL);
  assign resp_result_o = result_q;
  assign resp_id_o     = id_q;
  assign can_accept    = !resp_valid_o || resp_ready_i;
  assign req_ready_o   = grant & {NumReq{can_accept}};
  assign handshake     = |(req_valid_i & req_ready_o);

  // One-hot grant makes this an AND-OR mux of the winner's fields.
  always_comb begin
    sel_left    = 1'b0;
    sel_arith   = 1'b0;
    sel_operand = '0;
    sel_amount  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        sel_left    = req_left_i[i];
        sel_arith   = req_arith_i[i];
        sel_operand = req_operand_i[i*Width +: Width];
        sel_amount  = req_amount_i[i*AmtW +: AmtW];
      end
    end
  end

  panda_shifter #(
    .Width (Width)
  ) u_shifter (
    .left_i    (sel_left),
    .arith_i   (sel_arith),
    .operand_i (sel_operand),
    .amount_i  (sel_amount),
    .result_o  (shift_res)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    id_d     = id_q;
`ifdef PANDA_SHIFT_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      SLOT_EMPTY: if (handshake) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (handshake)         state_d = SLOT_FULL;
        else if (resp_ready_i) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (handshake) begin
      result_d = shift_res;
      id_d     = gnt_idx;
`ifdef PANDA_SHIFT_ARB_RR_EN
      ptr_d    = gnt_idx;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= SLOT_EMPTY;
      result_q <= '0;
      id_q     <= '0;
`ifdef PANDA_SHIFT_ARB_RR_EN
      ptr_q    <= IdW'(NumReq - 1);
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      id_q     <= id_d;
`ifdef PANDA_SHIFT_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_panda_shift_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_panda_shift_arbiter: directed self-checking bench, 2 requesters.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_panda_shift_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_left_i;
  logic [1:0]  req_arith_i;
  logic [63:0] req_operand_i;
  logic [9:0]  req_amount_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_result_o;
  logic [0:0]  resp_id_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_last_res;
  logic [31:0] exp_id;
  logic [31:0] exp_rdy;

  always #5 clk_i = ~clk_i;

  panda_shift_arbiter #(
    .Width  (32),
    .NumReq (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_left_i    (req_left_i),
    .req_arith_i   (req_arith_i),
    .req_operand_i (req_operand_i),
    .req_amount_i  (req_amount_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_result_o (resp_result_o),
    .resp_id_o     (resp_id_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic l, input logic a,
                         input logic [31:0] op, input logic [4:0] amt);
    req_left_i[i]          = l;
    req_arith_i[i]         = a;
    req_operand_i[i*32 +: 32] = op;
    req_amount_i[i*5 +: 5]    = amt;
  endtask

  // Called at a negedge with an idle consumer-ready slot.
  task automatic issue(input int i, input logic l, input logic a,
                       input logic [31:0] op, input logic [4:0] amt,
                       input logic [31:0] exp, input string tag);
    req_valid_i    = 2'b00;
    req_valid_i[i] = 1'b1;
    set_req(i, l, a, op, amt);
    #1 chk({tag, "_ready"}, 32'(req_ready_o), 32'(2'b01 << i));
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 2'b00;
    chk({tag, "_valid"}, 32'(resp_valid_o), 32'd1);
    chk({tag, "_result"}, resp_result_o, exp);
    chk({tag, "_id"}, 32'(resp_id_o), 32'(i));
  endtask

  initial begin
    rst_ni        = 1'b0;
    req_valid_i   = '0;
    req_left_i    = '0;
    req_arith_i   = '0;
    req_operand_i = '0;
    req_amount_i  = '0;
    resp_ready_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_result", resp_result_o, 32'd0);
    chk("rst_id", 32'(resp_id_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    rst_ni = 1'b1;

    issue(0, 1'b0, 1'b0, 32'd3429435, 5'd5, 32'd107169, "lsr");
    issue(1, 1'b0, 1'b1, -32'sd4358234, 5'd8, -32'sd17025, "asr");
    issue(0, 1'b1, 1'b0, -32'sd4358234, 5'd24, 32'hA600_0000, "lsl");
    issue(0, 1'b1, 1'b1, -32'sd4358234, 5'd24, 32'hA600_0000, "lsl_arith");
    issue(1, 1'b0, 1'b1, 32'h1234_5678, 5'd0, 32'h1234_5678, "amt0");
    issue(0, 1'b0, 1'b0, 32'hFFBD_7FA6, 5'd4, 32'h0FFB_D7FA, "lsr_neg");
    issue(1, 1'b0, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "asr31");
    @(posedge clk_i);
    @(negedge clk_i);
    chk("drained", 32'(resp_valid_o), 32'd0);

    // Contention: requester 0 yields 0x200, requester 1 yields 0x400.
    set_req(0, 1'b1, 1'b0, 32'h100, 5'd1);
    set_req(1, 1'b1, 1'b0, 32'h100, 5'd2);
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
`ifdef PANDA_SHIFT_ARB_RR_EN
      exp_id  = 32'(k % 2);
      exp_rdy = 32'(2'b01 << ((k + 1) % 2));
`else
      exp_id  = 32'd0;
      exp_rdy = 32'd1;
`endif
      chk("cont_id", 32'(resp_id_o), exp_id);
      chk("cont_result", resp_result_o, (exp_id == 0) ? 32'h200 : 32'h400);
      chk("cont_ready", 32'(req_ready_o), exp_rdy);
    end

    // Backpressure: hold slot for three cycles.
    exp_last_res = (exp_id == 0) ? 32'h200 : 32'h400;
    resp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_id", 32'(resp_id_o), exp_id);
      chk("bp_result", resp_result_o, exp_last_res);
    end
    resp_ready_i = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_next_valid", 32'(resp_valid_o), 32'd1);
    chk("bp_next_id", 32'(resp_id_o), 32'd0);
    chk("bp_next_result", resp_result_o, 32'h200);

    // Reset while full, requests still pending.
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
    chk("mid_rst_id", 32'(resp_id_o), 32'd0);
    chk("mid_rst_result", resp_result_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("post_rst_valid", 32'(resp_valid_o), 32'd1);
    chk("post_rst_id", 32'(resp_id_o), 32'd0);
    chk("post_rst_result", resp_result_o, 32'h200);
    req_valid_i = 2'b00;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("final_drain", 32'(resp_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
